// File: rtl/alarm_display_pkg.sv
// Shared register map, control-bit positions and sizing helpers for the alarm display scanner.
// Blink support is built only when ALARM_DISPLAY_BLINK_EN is defined.
package alarm_display_pkg;

    localparam int MAX_NUM_DIGITS = 8;
    localparam int IDX_W          = $clog2(MAX_NUM_DIGITS);

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_BLINK  = 4'd9;
    localparam logic [3:0] ADDR_STATUS = 4'd10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLANK = 1;
    localparam int CTRL_W     = 2;

    // Counter width for a modulo-n count; a modulo-1 counter still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_display_divider.sv
// Generic modulo-N counter with enable, synchronous clear and a terminal-count pulse.
// Used as the scan prescaler and as the blink frame counter.
module alarm_display_divider
    import alarm_display_pkg::*;
#(
    parameter int N = 2,
    localparam int CNT_W = cnt_width(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last  = (r_count == CNT_W'(N - 1));
    assign o_tc    = i_en & ~i_clr & w_last;
    assign o_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_display_scan.sv
// Avalon-MM multiplexed display scanner: digit registers, prescaled one-hot scan, blanking, status.
// Define ALARM_DISPLAY_BLINK_EN to build the BLINK_MASK register and blink phase logic.
module alarm_display_scan
    import alarm_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DIGIT_W-1:0]    seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_tick
);

    localparam int PRESC_W = cnt_width(SCAN_DIV);

    logic [DIGIT_W-1:0]    r_digit [NUM_DIGITS];
    logic [CTRL_W-1:0]     r_ctrl;
    logic [IDX_W-1:0]      r_index;
    logic [DIGIT_W-1:0]    r_seg_out;
    logic [NUM_DIGITS-1:0] r_dig_sel;

    logic                  w_wr;
    logic                  w_en_kill;
    logic                  w_active;
    logic                  w_slot_tick;
    logic                  w_last_digit;
    logic                  w_frame_wrap;
    logic [PRESC_W-1:0]    w_presc_count_unused;
    logic [NUM_DIGITS-1:0] w_blink_mask;
    logic                  w_blink_phase;
    logic [DIGIT_W-1:0]    w_cur_digit;
    logic                  w_cur_blink;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_unused_ok;

    assign w_wr = chipselect & ~write_n;

    // A CTRL write clearing EN must beat a coincident slot tick, so it gates the scan this edge.
    assign w_en_kill    = w_wr && (address == ADDR_CTRL) && !writedata[CTRL_EN];
    assign w_active     = r_ctrl[CTRL_EN] & ~w_en_kill;
    assign w_last_digit = (r_index == IDX_W'(NUM_DIGITS - 1));
    assign w_frame_wrap = w_slot_tick & w_last_digit;
    assign frame_tick   = w_frame_wrap;

    alarm_display_divider #(.N(SCAN_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_active),
        .i_clr   (~w_active),
        .o_count (w_presc_count_unused),
        .o_tc    (w_slot_tick)
    );

`ifdef ALARM_DISPLAY_BLINK_EN
    localparam int BLINK_W = cnt_width(BLINK_DIV);

    logic [NUM_DIGITS-1:0] r_blink_mask;
    logic                  r_blink_phase;
    logic                  w_blink_tc;
    logic [BLINK_W-1:0]    w_blink_count_unused;

    alarm_display_divider #(.N(BLINK_DIV)) u_blink_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_frame_wrap),
        .i_clr   (~w_active),
        .o_count (w_blink_count_unused),
        .o_tc    (w_blink_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_mask  <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_wr && (address == ADDR_BLINK)) begin
                r_blink_mask <= writedata[NUM_DIGITS-1:0];
            end
            if (!w_active) begin
                r_blink_phase <= 1'b0;
            end else if (w_blink_tc) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end

    assign w_blink_mask  = r_blink_mask;
    assign w_blink_phase = r_blink_phase;
    assign w_unused_ok   = ^{writedata, w_presc_count_unused, w_blink_count_unused};
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign w_blink_mask  = '0;
    assign w_blink_phase = 1'b0;
    assign w_unused_ok   = ^{writedata, w_presc_count_unused};
`endif

    // NOTE: digit registers are software-visible with defined reset values, so this array is reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_digit[k] <= '0;
            end
            r_ctrl <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (address == 4'(k)) begin
                    r_digit[k] <= writedata[DIGIT_W-1:0];
                end
            end
            if (address == ADDR_CTRL) begin
                r_ctrl <= writedata[CTRL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index <= '0;
        end else if (!w_active) begin
            r_index <= '0;
        end else if (w_slot_tick) begin
            r_index <= w_last_digit ? '0 : r_index + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_cur_digit = '0;
        w_cur_blink = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_index == IDX_W'(k)) begin
                w_cur_digit = r_digit[k];
                w_cur_blink = w_blink_mask[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_out <= '0;
            r_dig_sel <= '0;
        end else if (w_active) begin
            r_dig_sel <= w_onehot;
            r_seg_out <= (r_ctrl[CTRL_BLANK] || (w_cur_blink && w_blink_phase)) ? '0 : w_cur_digit;
        end else begin
            r_seg_out <= '0;
            r_dig_sel <= '0;
        end
    end

    assign seg_out = r_seg_out;
    assign dig_sel = r_dig_sel;

    always_comb begin
        readdata = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (address == 4'(k)) begin
                readdata = 32'(r_digit[k]);
            end
        end
        case (address)
            ADDR_CTRL:   readdata = 32'(r_ctrl);
            ADDR_BLINK:  readdata = 32'(w_blink_mask);
            ADDR_STATUS: readdata = 32'({w_blink_phase, r_index});
            default:     ;
        endcase
    end

endmodule
